param_stack: RTL and testbench

- Parametrised LIFO buffer, next generation of the lab's fixed 8x4 stack.
- Configurable data width and depth; registered pop output with a valid strobe; occupancy count; combinational top-of-stack peek; overflow/underflow error strobes.
- Sits between a producer issuing push and a consumer issuing pop, on a single clock domain.

---
 rtl/param_stack.sv | 100 ++++++++++
 tb/tb_param_stack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered pop data, occupancy count and error flags.
// Define PARAM_STACK_STICKY_ERR_EN to make overflow/underflow sticky until reset.
module param_stack #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_out_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic [IDX_W-1:0]      w_top_idx;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [DATA_WIDTH-1:0] w_top_word;
  logic                  w_pop_ok;
  logic                  w_grow;
  logic                  w_shrink;
  logic                  w_wr_en;
  logic                  w_ovf_ev;
  logic                  w_unf_ev;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  // Index is only used when the stack is non-empty, so the truncation is lossless.
  assign w_top_idx  = IDX_W'(r_count - CNT_W'(1));
  assign w_top_word = r_mem[w_top_idx];

  assign w_pop_ok = pop && !w_empty;
  assign w_grow   = push && !w_pop_ok && !w_full;
  assign w_shrink = w_pop_ok && !push;
  assign w_wr_en  = push && (w_pop_ok || !w_full);
  assign w_wr_idx = w_pop_ok ? w_top_idx : IDX_W'(r_count);
  assign w_ovf_ev = push && !pop && w_full;
  assign w_unf_ev = pop && w_empty;

  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[w_wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_grow) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_shrink) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_pop_ok) begin
        r_data_out <= w_top_word;
      end
      r_out_valid <= w_pop_ok;
`ifdef PARAM_STACK_STICKY_ERR_EN
      r_overflow  <= r_overflow | w_ovf_ev;
      r_underflow <= r_underflow | w_unf_ev;
`else
      r_overflow  <= w_ovf_ev;
      r_underflow <= w_unf_ev;
`endif
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign top       = w_empty ? '0 : w_top_word;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, a DEPTH=5 / 16-bit instance, and random traffic.
module tb_param_stack;

`ifdef PARAM_STACK_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: 4-bit words, 8 entries
  logic       push = 1'b0, pop = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] data_out, top;
  logic [3:0] count;
  logic       out_valid, full, empty, overflow, underflow;

  param_stack dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid), .top(top), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  // Sweep instance: 16-bit words, 5 entries
  logic        b_push = 1'b0, b_pop = 1'b0;
  logic [15:0] b_din = '0;
  logic [15:0] b_dout, b_top;
  logic [2:0]  b_cnt;
  logic        b_vld, b_full, b_empty, b_ovf, b_unf;

  param_stack #(.DATA_WIDTH(16), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .data_in(b_din),
    .data_out(b_dout), .out_valid(b_vld), .top(b_top), .count(b_cnt),
    .full(b_full), .empty(b_empty), .overflow(b_ovf), .underflow(b_unf)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model of the default instance: a queue whose back is the top of stack
  logic [3:0] q[$];
  logic [3:0] m_dout = '0;
  logic       m_vld = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (!STICKY) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (push && pop) begin
        if (q.size() == 0) begin
          q.push_back(data_in); m_unf = 1'b1;
        end else begin
          m_dout = q[q.size()-1]; q[q.size()-1] = data_in; m_vld = 1'b1;
        end
      end else if (push) begin
        if (q.size() == 8) m_ovf = 1'b1;
        else q.push_back(data_in);
      end else if (pop) begin
        if (q.size() == 0) m_unf = 1'b1;
        else begin m_dout = q.pop_back(); m_vld = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count", 32'(count), 32'(q.size()));
      check("m_top", 32'(top), (q.size() == 0) ? 32'd0 : 32'(q[q.size()-1]));
      check("m_full", 32'(full), 32'(q.size() == 8));
      check("m_empty", 32'(empty), 32'(q.size() == 0));
      check("m_data_out", 32'(data_out), 32'(m_dout));
      check("m_out_valid", 32'(out_valid), 32'(m_vld));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input logic p, input logic pp, input logic [3:0] d);
    push = p; pop = pp; data_in = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic cycb(input logic p, input logic pp, input logic [15:0] d);
    b_push = p; b_pop = pp; b_din = d;
    @(posedge clk); #1;
    b_push = 1'b0; b_pop = 1'b0;
  endtask

  int bias;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Asynchronous reset in the middle of a cycle
    for (int v = 1; v <= 4; v++) cyc(1'b1, 1'b0, 4'(v));
    cyc(1'b0, 1'b1, 4'd0);
    check("pre_rst_dout", 32'(data_out), 32'd4);
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_flags", {29'd0, out_valid, overflow, underflow}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Fill and drain
    for (int v = 1; v <= 8; v++) cyc(1'b1, 1'b0, 4'(v));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_top", 32'(top), 32'd8);
    for (int k = 8; k >= 1; k--) begin
      cyc(1'b0, 1'b1, 4'd0);
      check("drain_dout", 32'(data_out), 32'(k));
      check("drain_vld", 32'(out_valid), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Overflow, then replace while full
    for (int v = 1; v <= 8; v++) cyc(1'b1, 1'b0, 4'(v));
    cyc(1'b1, 1'b0, 4'd9);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_top", 32'(top), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 4'd0);
    check("ovf_after", 32'(overflow), 32'(STICKY));
    cyc(1'b0, 1'b1, 4'd0);
    check("ovf_pop_dout", 32'(data_out), 32'd8);
    cyc(1'b1, 1'b0, 4'd8);
    cyc(1'b1, 1'b1, 4'd7);
    check("rplf_dout", 32'(data_out), 32'd8);
    check("rplf_vld", 32'(out_valid), 32'd1);
    check("rplf_count", 32'(count), 32'd8);
    check("rplf_top", 32'(top), 32'd7);
    check("rplf_ovf", 32'(overflow), 32'(STICKY));

    // Underflow
    repeat (8) cyc(1'b0, 1'b1, 4'd0);
    check("unf_pre_dout", 32'(data_out), 32'd1);
    cyc(1'b0, 1'b1, 4'd0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_vld", 32'(out_valid), 32'd0);
    check("unf_dout", 32'(data_out), 32'd1);
    cyc(1'b1, 1'b1, 4'd5);
    check("unf_pp_count", 32'(count), 32'd1);
    check("unf_pp_top", 32'(top), 32'd5);
    check("unf_pp_flag", 32'(underflow), 32'd1);
    check("unf_pp_vld", 32'(out_valid), 32'd0);

    // Replace with a partly filled stack
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b1, 1'b0, 4'd3);
    cyc(1'b1, 1'b0, 4'd6);
    cyc(1'b1, 1'b1, 4'd7);
    check("rpl_dout", 32'(data_out), 32'd6);
    check("rpl_vld", 32'(out_valid), 32'd1);
    check("rpl_count", 32'(count), 32'd2);
    check("rpl_top", 32'(top), 32'd7);

    // Non-power-of-two depth, 16-bit words
    for (int v = 0; v < 5; v++) begin
      cycb(1'b1, 1'b0, 16'hA000 + 16'(v));
      check("b_count", 32'(b_cnt), 32'(v + 1));
      check("b_top", 32'(b_top), 32'hA000 + 32'(v));
    end
    check("b_full", 32'(b_full), 32'd1);
    cycb(1'b1, 1'b0, 16'hBEEF);
    check("b_ovf", 32'(b_ovf), 32'd1);
    check("b_ovf_count", 32'(b_cnt), 32'd5);
    for (int v = 4; v >= 0; v--) begin
      cycb(1'b0, 1'b1, 16'd0);
      check("b_dout", 32'(b_dout), 32'hA000 + 32'(v));
      check("b_vld", 32'(b_vld), 32'd1);
    end
    check("b_empty", 32'(b_empty), 32'd1);

    // Random traffic with occasional mid-cycle resets
    bias = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 128 == 0) bias = int'($urandom_range(15, 85));
      push    = (int'($urandom_range(0, 99)) < bias);
      pop     = (int'($urandom_range(0, 99)) < (100 - bias));
      data_in = 4'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #3 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    push = 1'b0; pop = 1'b0;
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
